ddr_read_buffer: RTL and testbench
==================================

Name: ddr_read_buffer

Overview:
- Downstream of the DDR controller, in the clk133_90 domain where read halves are captured.
- Accepts assembled 32-bit read words, one per valid cycle, and buffers them in a small FIFO.
- Presents them to the pixel pipeline over a valid/ready handshake.
- Issues credit-based burst requests to the controller so outstanding reads can never overflow the buffer.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- ADDR_W, 4, log2(DEPTH).
- BURST_WORDS, 4, words returned per controller read burst; must be at most DEPTH.

Ports:
- clk133_90  in  1  Clock. All logic samples on the rising edge.
- rst  in  1  Reset, asynchronous, active-high.
- enable  in  1  Permits new burst requests.
- flush  in  1  Synchronous discard of buffer contents and in-flight data.
- inData  in  32  Read word from the controller.
- inValid  in  1  inData valid this cycle.
- burstReq  out  1  Request one read burst of BURST_WORDS.
- burstAck  in  1  Controller accepted the request; its words follow.
- outData  out  32  Head-of-FIFO word.
- outValid  out  1  outData valid.
- outReady  in  1  Consumer takes outData when outValid and outReady are both high.
- level  out  ADDR_W+1  Current occupancy, 0 to DEPTH.
- overflow  out  1  Sticky: a word was dropped because the FIFO was full.
- protoErr  out  1  Sticky: inValid was received with pending==0 outside DRAIN.

Behaviour:
- Reset values: burstReq=0, outValid=0, level=0, overflow=0, protoErr=0, state=IDLE. wrPtr, rdPtr and pending are all 0. outData is don't-care.
- Storage:
  - DEPTH x 32 register array. wrPtr and rdPtr are ADDR_W bits and wrap modulo DEPTH.
  - count is ADDR_W+1 bits; level=count.
- Show-ahead output:
  - outData=mem[rdPtr]; outValid=(count!=0).
  - A word pushed at edge N is visible at outData with outValid=1 after edge N.
- Push: inValid with count<DEPTH writes mem[wrPtr] and increments wrPtr.
- Pop: outValid&&outReady increments rdPtr.
- Simultaneous push and pop:
  - Both happen and count is unchanged, including at count==DEPTH (pop frees the slot in the same cycle).
  - At count==0, only the push happens.
- Push while full with no pop: the word is dropped, overflow is set, and pending still decrements.
- Pop when empty: ignored.
- pending (ADDR_W+1 bits) counts words acknowledged but not yet received:
  - Adds BURST_WORDS on burstAck while burstReq=1.
  - Subtracts 1 on each inValid, saturating at 0.
  - inValid with pending==0 outside DRAIN sets protoErr and the word is still pushed if there is room.
  - Ack and inValid in the same cycle change pending by BURST_WORDS-1.
- FSM IDLE / REQ / DRAIN:
  - IDLE: if enable && !flush && count+pending+BURST_WORDS<=DEPTH, go to REQ. Evaluate the sum with ADDR_W+2 bits.
  - REQ: burstReq=1 and is held until burstAck. burstAck samples go to IDLE. Deasserting enable does not withdraw a pending request.
  - A new request cannot be raised the cycle after an ack; at least one IDLE cycle is required.
  - burstAck while burstReq=0 is ignored.
- Flush, from any state:
  - Next cycle: wrPtr=rdPtr=0, count=0, outValid=0.
  - In REQ, burstReq drops immediately; an ack sampled in the flush cycle is still credited to pending.
  - If the resulting pending!=0, go to DRAIN, else go to IDLE.
- DRAIN:
  - Incoming words decrement pending and are discarded, not stored. burstReq=0.
  - Go to IDLE when pending reaches 0.
  - flush held in DRAIN stays in DRAIN.
- Sticky flags clear only on rst, not on flush.
- rst mid-burst: everything returns to reset values immediately; words still arriving afterwards set protoErr.

Test Plan:
- Reset, then enable=1 with DEPTH=16, BURST_WORDS=4 and ack 1 cycle after each request:
  - Requests stop after 4 acks (pending+count=16).
  - Deliver 16 words 0x0..0xF; the consumer pops 0x0..0xF in order.
  - level peaks at 16; overflow=0.
- Fill to 16 with outReady=0, then push 0xAAAA5555 with no pop:
  - The word is dropped, overflow=1, level stays 16.
  - Popping yields the original 16 words.
- At count=16, assert push and pop in the same cycle:
  - level stays 16 and the new word appears last.
  - wrPtr wrap is verified by 40 further streamed words arriving intact.
- Ack one burst, deliver 1 word, then flush:
  - level=0, outValid=0, state=DRAIN, pending=3.
  - The next 3 words are discarded, then IDLE and requests resume.
- inValid with no prior ack: protoErr=1, the word is stored (level=1), pending stays 0.
- Hold burstReq for 7 cycles before acking, and deassert enable during the wait:
  - burstReq stays 1 until the ack, then no further requests are made.

Source files
------------

// File: rtl/ddr_read_buffer.sv
// ddr_read_buffer
// Read-return buffer that sits after the DDR controller in the clk133_90
// capture domain. Assembled 32-bit read words go into a small show-ahead
// FIFO. The FIFO feeds the pixel pipeline over a valid/ready handshake.
// Burst requests to the controller are credit based: a request is only raised
// when the words it will return are guaranteed to fit alongside everything
// already buffered or still in flight.
//
// Ports:
//   clk133_90  rising-edge clock
//   rst        asynchronous active-high reset
//   enable     permits new burst requests
//   flush      discard buffered and in-flight data
//   inData     read word from the controller
//   inValid    inData valid this cycle
//   burstReq   request one burst of BURST_WORDS words
//   burstAck   controller accepted the request
//   outData    head-of-FIFO word
//   outValid   outData valid
//   outReady   consumer takes outData when outValid && outReady
//   level      current FIFO occupancy, 0..DEPTH
//   overflow   sticky: a word was dropped because the FIFO was full
//   protoErr   sticky: a word arrived without outstanding credit
module ddr_read_buffer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int BURST_WORDS = 4
) (
  input  logic            clk133_90,
  input  logic            rst,
  input  logic            enable,
  input  logic            flush,
  input  logic [31:0]     inData,
  input  logic            inValid,
  output logic            burstReq,
  input  logic            burstAck,
  output logic [31:0]     outData,
  output logic            outValid,
  input  logic            outReady,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  output logic            protoErr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   BURST_C = (ADDR_W + 1)'(BURST_WORDS);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = (ADDR_W)'(1);

  state_t              state_q, state_d;
  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         mem_d [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     pending_q, pending_d;
  logic                overflow_q, overflow_d;
  logic                proto_err_q, proto_err_d;

  logic                credit, accept, full, push, pop, drop;
  logic [ADDR_W+1:0]   room_sum;

  assign outData  = mem_q[rd_ptr_q];
  assign outValid = (count_q != '0);
  assign level    = count_q;
  assign overflow = overflow_q;
  assign protoErr = proto_err_q;

  // Datapath: push/pop decisions, pointer and occupancy updates, and the
  // credit counter. The ack is credited on the registered REQ state rather
  // than on burstReq, so an ack that lands in a flush cycle still counts.
  always_comb begin
    credit   = burstAck && (state_q == REQ);
    pop      = outValid && outReady && !flush;
    accept   = inValid && !flush && (state_q != DRAIN);
    full     = (count_q == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = accept && (!full || pop);
    drop     = accept && full && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = inData;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + ONE_C;
    end else if (pop && !push) begin
      count_d = count_q - ONE_C;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // Adding the credit first keeps ack+word in one cycle at BURST_WORDS-1
    // even when nothing was outstanding; the decrement saturates at zero.
    pending_d = pending_q;
    if (credit) begin
      pending_d = pending_d + BURST_C;
    end
    if (inValid && (pending_d != '0)) begin
      pending_d = pending_d - ONE_C;
    end

    overflow_d  = overflow_q || drop;
    proto_err_d = proto_err_q ||
                  (inValid && (pending_q == '0) && (state_q != DRAIN));
  end

  // Request FSM. The sum is one bit wider than the counters so that
  // count + pending + BURST_WORDS cannot wrap when the buffer is committed.
  always_comb begin
    state_d  = state_q;
    burstReq = 1'b0;
    room_sum = {1'b0, count_q} + {1'b0, pending_q} + {1'b0, BURST_C};

    unique case (state_q)
      IDLE: begin
        if (enable && !flush && (room_sum <= {1'b0, DEPTH_C})) begin
          state_d = REQ;
        end
      end
      REQ: begin
        burstReq = !flush;
        if (burstAck) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (pending_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = (pending_d != '0) ? DRAIN : IDLE;
    end
  end

  // Control registers. The async reset returns every register to its idle
  // value immediately, including the sticky flags.
  always_ff @(posedge clk133_90 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage array. Its contents are don't-care after reset because
  // outValid masks them.
  always_ff @(posedge clk133_90) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ddr_read_buffer.sv
// tb_ddr_read_buffer
// Directed test of ddr_read_buffer with DEPTH=16, BURST_WORDS=4. Inputs are
// driven 1 time unit after each rising edge. Outputs are sampled at the same
// point.
module tb_ddr_read_buffer;

  logic        clk133_90;
  logic        rst;
  logic        enable;
  logic        flush;
  logic [31:0] inData;
  logic        inValid;
  logic        burstReq;
  logic        burstAck;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady;
  logic [4:0]  level;
  logic        overflow;
  logic        protoErr;

  int          errors;
  int          checks;
  logic [31:0] exp_q[$];

  ddr_read_buffer #(
    .DEPTH(16),
    .ADDR_W(4),
    .BURST_WORDS(4)
  ) dut (
    .clk133_90(clk133_90),
    .rst(rst),
    .enable(enable),
    .flush(flush),
    .inData(inData),
    .inValid(inValid),
    .burstReq(burstReq),
    .burstAck(burstAck),
    .outData(outData),
    .outValid(outValid),
    .outReady(outReady),
    .level(level),
    .overflow(overflow),
    .protoErr(protoErr)
  );

  initial clk133_90 = 1'b0;
  always #5 clk133_90 = ~clk133_90;

  task automatic cycle();
    @(posedge clk133_90);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    enable   = 1'b0;
    flush    = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    burstAck = 1'b0;
    outReady = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    inValid = 1'b1;
    inData  = d;
    cycle();
    inValid = 1'b0;
  endtask

  // Grants n bursts, dropping enable with the last ack so that no further
  // request follows.
  task automatic grant(input int n);
    int acks;
    acks   = 0;
    enable = 1'b1;
    for (int c = 0; c < 100 && acks < n; c++) begin
      if (burstReq) begin
        burstAck = 1'b1;
        acks++;
        if (acks == n) enable = 1'b0;
      end
      cycle();
      burstAck = 1'b0;
    end
    enable = 1'b0;
    checks++;
    if (acks != n) begin
      errors++;
      $display("[TB] FAIL grant_timeout: got %0d acks expected %0d", acks, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (burstReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_burstReq: got %b expected 0", burstReq); end
    checks++;
    if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_outValid: got %b expected 0", outValid); end
    checks++;
    if (level !== 5'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    checks++;
    if (protoErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_protoErr: got %b expected 0", protoErr); end
    checks++;
    if (dut.pending_q !== 5'd0) begin errors++; $display("[TB] FAIL reset_pending: got %0d expected 0", dut.pending_q); end
  endtask

  task automatic test_credit_and_order();
    int acks;
    int peak;
    do_reset();
    enable = 1'b1;
    acks   = 0;
    for (int c = 0; c < 40; c++) begin
      burstAck = burstReq;
      if (burstReq) acks++;
      cycle();
    end
    burstAck = 1'b0;
    checks++;
    if (acks != 4) begin errors++; $display("[TB] FAIL credit_acks: got %0d expected 4", acks); end
    checks++;
    if (burstReq !== 1'b0) begin errors++; $display("[TB] FAIL credit_stopped: got %b expected 0", burstReq); end
    checks++;
    if (dut.pending_q !== 5'd16) begin errors++; $display("[TB] FAIL credit_pending: got %0d expected 16", dut.pending_q); end
    enable = 1'b0;
    peak   = 0;
    for (int i = 0; i < 16; i++) begin
      push_word(32'(i));
      if (int'(level) > peak) peak = int'(level);
    end
    checks++;
    if (peak != 16) begin errors++; $display("[TB] FAIL order_peak: got %0d expected 16", peak); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL order_overflow: got %b expected 0", overflow); end
    checks++;
    if (protoErr !== 1'b0) begin errors++; $display("[TB] FAIL order_protoErr: got %b expected 0", protoErr); end
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== 32'(i)) begin
        errors++;
        $display("[TB] FAIL order_pop%0d: got valid=%b data=%h expected valid=1 data=%h", i, outValid, outData, i);
      end
      cycle();
    end
    outReady = 1'b0;
    checks++;
    if (level !== 5'd0 || outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL order_empty: got level=%0d valid=%b expected 0/0", level, outValid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    grant(4);
    for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i));
    checks++;
    if (level !== 5'd16) begin errors++; $display("[TB] FAIL ovf_fill: got %0d expected 16", level); end
    push_word(32'hAAAA5555);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    checks++;
    if (level !== 5'd16) begin errors++; $display("[TB] FAIL ovf_level: got %0d expected 16", level); end
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== 32'h100 + 32'(i)) begin
        errors++;
        $display("[TB] FAIL ovf_pop%0d: got valid=%b data=%h expected valid=1 data=%h", i, outValid, outData, 32'h100 + 32'(i));
      end
      cycle();
    end
    outReady = 1'b0;
    checks++;
    if (level !== 5'd0) begin errors++; $display("[TB] FAIL ovf_drained: got %0d expected 0", level); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    do_reset();
    exp_q.delete();
    grant(4);
    for (int i = 0; i < 16; i++) begin
      push_word(32'h200 + 32'(i));
      exp_q.push_back(32'h200 + 32'(i));
    end
    // First iteration is the push+pop at count 16, then 40 streamed words.
    for (int i = 0; i < 41; i++) begin
      d        = (i == 0) ? 32'h2FF : 32'h300 + 32'(i - 1);
      inValid  = 1'b1;
      inData   = d;
      outReady = 1'b1;
      checks++;
      if (outValid !== 1'b1 || outData !== exp_q[0]) begin
        errors++;
        $display("[TB] FAIL stream_head%0d: got valid=%b data=%h expected valid=1 data=%h", i, outValid, outData, exp_q[0]);
      end
      void'(exp_q.pop_front());
      exp_q.push_back(d);
      cycle();
      checks++;
      if (level !== 5'd16) begin errors++; $display("[TB] FAIL stream_level%0d: got %0d expected 16", i, level); end
    end
    inValid = 1'b0;
    for (int i = 0; i < 16 && exp_q.size() > 0; i++) begin
      checks++;
      if (outValid !== 1'b1 || outData !== exp_q[0]) begin
        errors++;
        $display("[TB] FAIL stream_tail%0d: got valid=%b data=%h expected valid=1 data=%h", i, outValid, outData, exp_q[0]);
      end
      void'(exp_q.pop_front());
      cycle();
    end
    outReady = 1'b0;
    checks++;
    if (level !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_end: got level=%0d overflow=%b expected 0/0", level, overflow);
    end
  endtask

  task automatic test_flush_drain();
    do_reset();
    grant(1);
    push_word(32'h400);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (level !== 5'd0 || outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_empty: got level=%0d valid=%b expected 0/0", level, outValid);
    end
    checks++;
    if (dut.state_q !== 2'd2) begin errors++; $display("[TB] FAIL flush_state: got %0d expected 2", dut.state_q); end
    checks++;
    if (dut.pending_q !== 5'd3) begin errors++; $display("[TB] FAIL flush_pending: got %0d expected 3", dut.pending_q); end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_word(32'h500 + 32'(i));
      checks++;
      if (burstReq !== 1'b0 || level !== 5'd0) begin
        errors++;
        $display("[TB] FAIL drain_word%0d: got req=%b level=%0d expected 0/0", i, burstReq, level);
      end
    end
    checks++;
    if (dut.state_q !== 2'd0 || dut.pending_q !== 5'd0) begin
      errors++;
      $display("[TB] FAIL drain_done: got state=%0d pending=%0d expected 0/0", dut.state_q, dut.pending_q);
    end
    cycle();
    checks++;
    if (burstReq !== 1'b1) begin errors++; $display("[TB] FAIL drain_resume: got %b expected 1", burstReq); end
    burstAck = 1'b1;
    enable   = 1'b0;
    cycle();
    burstAck = 1'b0;
    checks++;
    if (protoErr !== 1'b0) begin errors++; $display("[TB] FAIL drain_protoErr: got %b expected 0", protoErr); end
  endtask

  task automatic test_proto_err();
    do_reset();
    push_word(32'h600);
    checks++;
    if (protoErr !== 1'b1) begin errors++; $display("[TB] FAIL proto_flag: got %b expected 1", protoErr); end
    checks++;
    if (level !== 5'd1 || outData !== 32'h600) begin
      errors++;
      $display("[TB] FAIL proto_stored: got level=%0d data=%h expected 1/00000600", level, outData);
    end
    checks++;
    if (dut.pending_q !== 5'd0) begin errors++; $display("[TB] FAIL proto_pending: got %0d expected 0", dut.pending_q); end
  endtask

  task automatic test_long_ack();
    int held;
    int extra;
    do_reset();
    enable = 1'b1;
    cycle();
    checks++;
    if (burstReq !== 1'b1) begin errors++; $display("[TB] FAIL hold_raise: got %b expected 1", burstReq); end
    held = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) enable = 1'b0;
      cycle();
      if (burstReq === 1'b1) held++;
    end
    checks++;
    if (held != 6) begin errors++; $display("[TB] FAIL hold_cycles: got %0d expected 6", held); end
    burstAck = 1'b1;
    cycle();
    burstAck = 1'b0;
    checks++;
    if (burstReq !== 1'b0 || dut.pending_q !== 5'd4) begin
      errors++;
      $display("[TB] FAIL hold_ack: got req=%b pending=%0d expected 0/4", burstReq, dut.pending_q);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (burstReq !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("[TB] FAIL hold_no_more: got %0d request cycles expected 0", extra); end
  endtask

  task automatic test_rst_mid_burst();
    do_reset();
    grant(1);
    push_word(32'h700);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (level !== 5'd0 || outValid !== 1'b0 || burstReq !== 1'b0 || dut.pending_q !== 5'd0) begin
      errors++;
      $display("[TB] FAIL rst_async: got level=%0d valid=%b req=%b pending=%0d expected 0/0/0/0",
               level, outValid, burstReq, dut.pending_q);
    end
    rst = 1'b0;
    push_word(32'h701);
    checks++;
    if (protoErr !== 1'b1 || level !== 5'd1 || outData !== 32'h701) begin
      errors++;
      $display("[TB] FAIL rst_late_word: got protoErr=%b level=%0d data=%h expected 1/1/00000701",
               protoErr, level, outData);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_credit_and_order();
    test_overflow();
    test_full_push_pop();
    test_flush_drain();
    test_proto_err();
    test_long_ack();
    test_rst_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
